iter_divider: RTL and testbench

- Multi-cycle restoring integer divider. It sits in the EX stage beside the ALU and produces one quotient bit per cycle.
- Each cycle it feeds a shifted partial remainder and the divisor into the 64-bit adder_subtractor (sub tied 1), then consumes that unit's result and carry_out.
- The hazard unit stalls the pipeline on busy and writes back quotient/remainder on done.

---
 rtl/div_pkg.sv | 29 ++
 rtl/iter_divider_if.sv | 53 +++++
 rtl/adder_subtractor.sv | 27 ++
 rtl/iter_divider.sv | 168 ++++++++++++++++
 tb/tb_iter_divider.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the iterative restoring divider.
//   DIV_BITS    : operand/result width
//   CNT_W       : width of the per-bit iteration counter
//   DIV_LATENCY : cycles from start being driven to the done pulse being
//                 visible (one extra FIXUP cycle when ITER_DIVIDER_SIGNED_EN
//                 is defined)
//   state_t     : divider control states
// ----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_BITS = 64;
  localparam int CNT_W    = $clog2(DIV_BITS);

`ifdef ITER_DIVIDER_SIGNED_EN
  localparam int DIV_LATENCY = DIV_BITS + 2;
`else
  localparam int DIV_LATENCY = DIV_BITS + 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/iter_divider_if.sv
// ----------------------------------------------------------------------------
// iter_divider_if
// Request/result bundle between the EX-stage issue logic (master) and the
// divider (slave).
//   start, dividend, divisor, is_signed (ITER_DIVIDER_SIGNED_EN only) : request
//   busy, done, quotient, remainder, div_zero                          : result
//   dbg_state                                                          : FSM state
//
// Handshake: start is the request valid and !busy is the ready. A request is
// taken on any rising edge where start=1 and busy=0 (IDLE or DONE); a start
// while busy is dropped, not queued. done is a single-cycle pulse and the
// results stay valid from that cycle until the next accepted start.
// ----------------------------------------------------------------------------
interface iter_divider_if
  import div_pkg::*;
#(
  parameter int BITS = DIV_BITS
) ();

  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
`ifdef ITER_DIVIDER_SIGNED_EN
  logic            is_signed;
`endif
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_zero;
  state_t          dbg_state;

`ifdef ITER_DIVIDER_SIGNED_EN
  modport master (
    output start, dividend, divisor, is_signed,
    input  busy, done, quotient, remainder, div_zero, dbg_state
  );
  modport slave (
    input  start, dividend, divisor, is_signed,
    output busy, done, quotient, remainder, div_zero, dbg_state
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, dbg_state
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, dbg_state
  );
`endif

endinterface

// File: rtl/adder_subtractor.sv
// ----------------------------------------------------------------------------
// adder_subtractor
// Combinational BITS-wide adder/subtractor shared with the ALU datapath.
//   a, b      : operands
//   sub       : 1 -> result = a - b (two's complement), 0 -> result = a + b
//   result    : sum/difference
//   carry_out : carry out of the MSB; for subtraction 1 means no borrow
//   overflow  : signed overflow
// ----------------------------------------------------------------------------
module adder_subtractor #(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            sub,
  output logic [BITS-1:0] result,
  output logic            carry_out,
  output logic            overflow
);

  logic [BITS-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {carry_out, result} = {1'b0, a} + {1'b0, b_eff} + {{BITS{1'b0}}, sub};
  assign overflow = (a[BITS-1] == b_eff[BITS-1]) && (result[BITS-1] != a[BITS-1]);

endmodule

// File: rtl/iter_divider.sv
// ----------------------------------------------------------------------------
// iter_divider
// Multi-cycle restoring integer divider, one quotient bit per cycle, using a
// shared adder_subtractor in subtract mode.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : iter_divider_if.slave (request, results, dbg_state)
// Optional build macro ITER_DIVIDER_SIGNED_EN adds is_signed and a FIXUP
// state that restores operand signs after the magnitude division.
// ----------------------------------------------------------------------------
module iter_divider
  import div_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input  logic           clk,
  input  logic           reset,
  iter_divider_if.slave  bus
);

  localparam int            CW   = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BITS-1:0] r_q, r_d;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS-1:0] d_q, d_d;
  logic [BITS-1:0] quotient_q, quotient_d;
  logic [BITS-1:0] remainder_q, remainder_d;
  logic            div_zero_q, div_zero_d;
`ifdef ITER_DIVIDER_SIGNED_EN
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            dvd_neg, dvs_neg;

  assign dvd_neg = bus.is_signed & bus.dividend[BITS-1];
  assign dvs_neg = bus.is_signed & bus.divisor[BITS-1];
`endif

  // Shifted partial remainder is BITS+1 wide: 2R+1 can exceed 2^BITS-1, and
  // when its top bit is set the subtraction must be accepted regardless of
  // the adder's borrow.
  logic [BITS:0]   rs_full;
  logic [BITS-1:0] add_res;
  logic            add_co;
  logic            accept;
  logic [BITS-1:0] r_step;
  logic [BITS-1:0] q_step;

  assign rs_full = {r_q, q_q[BITS-1]};
  assign accept  = rs_full[BITS] | add_co;
  assign r_step  = accept ? add_res : rs_full[BITS-1:0];
  assign q_step  = {q_q[BITS-2:0], accept};

  adder_subtractor #(.BITS(BITS)) u_addsub (
    .a         (rs_full[BITS-1:0]),
    .b         (d_q),
    .sub       (1'b1),
    .result    (add_res),
    .carry_out (add_co),
    .overflow  ()
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
`ifdef ITER_DIVIDER_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide by zero bypasses the iteration entirely.
            quotient_d  = '1;
            remainder_d = bus.dividend;
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            r_d        = '0;
            count_d    = '0;
            div_zero_d = 1'b0;
            state_d    = RUN;
`ifdef ITER_DIVIDER_SIGNED_EN
            q_d     = dvd_neg ? -bus.dividend : bus.dividend;
            d_d     = dvs_neg ? -bus.divisor : bus.divisor;
            neg_q_d = dvd_neg ^ dvs_neg;
            neg_r_d = dvd_neg;
`else
            q_d     = bus.dividend;
            d_d     = bus.divisor;
`endif
          end
        end
      end
      RUN: begin
        r_d = r_step;
        q_d = q_step;
        if (count_q == LAST) begin
`ifdef ITER_DIVIDER_SIGNED_EN
          state_d = FIXUP;
`else
          quotient_d  = q_step;
          remainder_d = r_step;
          state_d     = DONE;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end
`ifdef ITER_DIVIDER_SIGNED_EN
      FIXUP: begin
        // MIN/-1: magnitude 2^(BITS-1) negates back to MIN, so no trap.
        quotient_d  = neg_q_q ? -q_q : q_q;
        remainder_d = neg_r_q ? -r_q : r_q;
        state_d     = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == FIXUP);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_iter_divider.sv
// ----------------------------------------------------------------------------
// tb_iter_divider
// Self-checking bench for iter_divider: directed cases plus randomized
// operands compared against plain-arithmetic expected results.
// ----------------------------------------------------------------------------
module tb_iter_divider;
  import div_pkg::*;

  localparam int W = DIV_BITS;

  logic clk = 1'b0;
  logic reset;

  iter_divider_if #(.BITS(W)) bus ();

  iter_divider #(.BITS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];  // triples: quotient, remainder, div_zero

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division semantics.
  function automatic void predict(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] q, r;
    logic         z;
    longint       sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (s) begin
      if (sb == -1) begin
        q = -a;   // MIN / -1 wraps back to MIN
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    exp_q.push_back(q);
    exp_q.push_back(r);
    exp_q.push_back({{(W-1){1'b0}}, z});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef ITER_DIVIDER_SIGNED_EN
    bus.is_signed = s;
`endif
    predict(a, b, s);
  endtask

  // Counts observations (one per cycle) until done, bounded.
  task automatic wait_done(input string tag, input int lat0, input int busy0,
                           output int lat, output int busy_n);
    lat    = lat0;
    busy_n = busy0;
    while (!bus.done && lat < 300) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, " done_seen"}, W'(bus.done), W'(1));
  endtask

  task automatic check_result(input string tag, input int lat, input int busy_n, input int exp_lat);
    logic [W-1:0] eq, er, ez;
    if (exp_q.size() < 3) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s scoreboard: observed empty queue expected 3 entries", tag);
    end else begin
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      ez = exp_q.pop_front();
      check({tag, " quotient"},  bus.quotient,      eq);
      check({tag, " remainder"}, bus.remainder,     er);
      check({tag, " div_zero"},  W'(bus.div_zero),  ez);
      check({tag, " latency"},   W'(lat),           W'(exp_lat));
      check({tag, " busy_cyc"},  W'(busy_n),        W'(exp_lat - 1));
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int lat, bn, exp_lat;
    exp_lat = (b == '0) ? 1 : DIV_LATENCY;
    start_op(a, b, s);
    tick();
    bus.start = 1'b0;
    wait_done(tag, 1, 0, lat, bn);
    check_result(tag, lat, bn, exp_lat);
    tick();
    check({tag, " done_pulse"}, W'(bus.done), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bn, seen;
    logic [W-1:0] a, b, min_v;
    logic         s;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef ITER_DIVIDER_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;

    check("rst busy",      W'(bus.busy),      W'(0));
    check("rst done",      W'(bus.done),      W'(0));
    check("rst quotient",  bus.quotient,      '0);
    check("rst remainder", bus.remainder,     '0);
    check("rst div_zero",  W'(bus.div_zero),  W'(0));
    check("rst state",     W'(bus.dbg_state), W'(IDLE));

    // Basic, msb-accept path, divide by zero.
    do_op("t1", 64'd100, 64'd7, 1'b0);
    do_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0);
    do_op("t3", 64'h1234, 64'd0, 1'b0);

    // Reset mid-RUN aborts with no done pulse.
    start_op(64'd50, 64'd5, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t4 busy",      W'(bus.busy),      W'(0));
    check("t4 done",      W'(bus.done),      W'(0));
    check("t4 quotient",  bus.quotient,      '0);
    check("t4 remainder", bus.remainder,     '0);
    check("t4 div_zero",  W'(bus.div_zero),  W'(0));
    check("t4 state",     W'(bus.dbg_state), W'(IDLE));
    seen = 0;
    repeat (70) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    check("t4 no_done", W'(seen), W'(0));
    do_op("t4b", 64'd9, 64'd4, 1'b0);

    // Back-to-back start in the done cycle, plus an ignored mid-RUN start.
    start_op(64'd8, 64'd8, 1'b0);
    tick();
    bus.start = 1'b0;
    wait_done("t5a", 1, 0, lat, bn);
    check_result("t5a", lat, bn, DIV_LATENCY);
    start_op(64'd20, 64'd3, 1'b0);
    tick();
    bus.start = 1'b0;
    check("t5 no_gap_state", W'(bus.dbg_state), W'(RUN));
    check("t5 no_gap_busy",  W'(bus.busy),      W'(1));
    check("t5 held_quot",    bus.quotient,      64'd1);
    lat = 1;
    bn  = 0;
    repeat (10) begin
      if (bus.busy) bn++;
      tick();
      lat++;
    end
    bus.start    = 1'b1;
    bus.dividend = 64'd1;
    bus.divisor  = 64'd1;
    if (bus.busy) bn++;
    tick();
    lat++;
    bus.start = 1'b0;
    wait_done("t5b", lat, bn, lat, bn);
    check_result("t5b", lat, bn, DIV_LATENCY);
    tick();

`ifdef ITER_DIVIDER_SIGNED_EN
    min_v = 64'h8000_0000_0000_0000;
    do_op("t6a", -64'd7, 64'd2, 1'b1);
    do_op("t6b", min_v, '1, 1'b1);
    do_op("t6c", -64'd5, 64'd0, 1'b1);
    do_op("t6d", 64'd100, -64'd7, 1'b1);
`else
    min_v = '0;
`endif

    // Randomized operands.
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a = a | min_v;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 100));
        2:       b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
`ifdef ITER_DIVIDER_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      do_op($sformatf("rnd%0d", i), a, b, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
